// File: rtl/ddr_bridge_pkg.sv
// ddr_bridge_pkg: shared constants and types for the cache-to-DDR3 command bridge.
//   APP_CMD_*   : command codes driven on app_cmd of the DDR IP user port
//   FIFO_CMD_*  : command type codes on the cache-side FIFO interface
//   state_t     : bridge FSM encoding (also exported on dbg_state)
//   cmd_entry_t : one command FIFO entry {type, addr, burst_cnt, data, mask}
package ddr_bridge_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam logic FIFO_CMD_WT = 1'b0;
  localparam logic FIFO_CMD_RD = 1'b1;

  localparam int ADDR_W  = 27;
  localparam int BURST_W = 6;
  localparam int DATA_W  = 128;
  localparam int MASK_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_CMD  = 3'd2,
    ST_RD_CMD  = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_t;

  typedef struct packed {
    logic               cmd_type;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst_cnt;
    logic [DATA_W-1:0]  data;
    logic [MASK_W-1:0]  mask;
  } cmd_entry_t;

  localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

  // DDR user port addresses whole 16-byte lines.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & ~27'hF;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   push/push_data : write an entry (accepted when not full, or when full and
//                    popping in the same cycle)
//   pop            : consume the head entry (ignored when empty)
//   head_data      : current head entry, valid whenever empty=0
//   empty          : no entries stored
//   free_cnt       : number of unoccupied entries (0..DEPTH)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign free_cnt  = FULL_CNT - count_q;

endmodule

// File: rtl/ddr_cmd_bridge.sv
// ddr_cmd_bridge: turns the line cache's FIFO command/response interface into
// Gowin DDR3 IP user-port (app_*) transactions, one DDR command at a time.
//   io_fifo_cmd_*     : cache command in (write data+mask, or read burst)
//   io_fifo_rsp_*     : read beats back to the cache (FWFT)
//   init_calib_complete : gates acceptance of new commands only
//   app_*             : DDR IP user port; all strobes are registered
//   err_burst         : sticky flag for an illegal burst_cnt
//   dbg_state         : current FSM state (state_t encoding)
// Handshakes: a transfer happens on a rising edge where valid (or en/wren) and
// the matching ready are both high; a raised strobe and its data/address are
// held unchanged until that edge. app_rd_data_valid has no back-pressure: read
// commands are only issued once the response FIFO has room for every beat.
module ddr_cmd_bridge
  import ddr_bridge_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_fifo_cmd_valid,
  output logic                io_fifo_cmd_ready,
  input  logic                io_fifo_cmd_type,
  input  logic [ADDR_W-1:0]   io_fifo_cmd_addr,
  input  logic [BURST_W-1:0]  io_fifo_cmd_burst_cnt,
  input  logic [DATA_W-1:0]   io_fifo_cmd_wt_data,
  input  logic [MASK_W-1:0]   io_fifo_cmd_wt_mask,
  output logic                io_fifo_rsp_valid,
  input  logic                io_fifo_rsp_ready,
  output logic [DATA_W-1:0]   io_fifo_rsp_data,
  input  logic                init_calib_complete,
  output logic                app_cmd_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [BURST_W-1:0]  app_burst_number,
  input  logic                app_cmd_rdy,
  output logic                app_wren,
  output logic [DATA_W-1:0]   app_wdata,
  output logic [MASK_W-1:0]   app_data_mask,
  output logic                app_wdata_end,
  input  logic                app_wdata_rdy,
  input  logic                app_rd_data_valid,
  input  logic [DATA_W-1:0]   app_rd_data,
  output logic                err_burst,
  output logic [2:0]          dbg_state
);

  localparam int CFW = $clog2(CMD_DEPTH) + 1;
  localparam int RFW = $clog2(RSP_DEPTH) + 1;

  cmd_entry_t         cmd_in, cmd_head;
  logic               cmd_empty, cmd_pop, cmd_push;
  logic [CFW-1:0]     cmd_free;
  logic               rsp_empty, rsp_push;
  logic [RFW-1:0]     rsp_free;

  state_t             state_q, state_d;
  logic               cmd_en_q, cmd_en_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               wren_q, wren_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [MASK_W-1:0]  mask_q, mask_d;
  logic [BURST_W:0]   beats_q, beats_d;
  logic               err_q, err_d;

  logic               burst_bad, rsp_fits;
  logic [BURST_W-1:0] eff_burst;

  assign cmd_in   = {io_fifo_cmd_type, io_fifo_cmd_addr, io_fifo_cmd_burst_cnt,
                     io_fifo_cmd_wt_data, io_fifo_cmd_wt_mask};
  assign io_fifo_cmd_ready = (cmd_free != '0) && init_calib_complete;
  assign cmd_push = io_fifo_cmd_valid && io_fifo_cmd_ready;

  sync_fifo #(.WIDTH(CMD_ENTRY_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .head_data (cmd_head),
    .empty     (cmd_empty),
    .free_cnt  (cmd_free)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (app_rd_data),
    .pop       (io_fifo_rsp_ready),
    .head_data (io_fifo_rsp_data),
    .empty     (rsp_empty),
    .free_cnt  (rsp_free)
  );

  assign io_fifo_rsp_valid = !rsp_empty;

  // Writes are always single-beat; reads may not exceed the response FIFO.
  // An illegal burst is flagged and then executed as a single beat.
  assign burst_bad = ((cmd_head.cmd_type == FIFO_CMD_WT) && (cmd_head.burst_cnt != '0)) ||
                     (32'(cmd_head.burst_cnt) >= RSP_DEPTH);
  assign eff_burst = burst_bad ? '0 : cmd_head.burst_cnt;
  // free >= burst+1: reserve room for every beat before the command goes out.
  assign rsp_fits  = 32'(rsp_free) > 32'(eff_burst);

  always_comb begin
    state_d  = state_q;
    cmd_en_d = cmd_en_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    wren_d   = wren_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    beats_d  = beats_q;
    err_d    = err_q;
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cmd_empty) begin
          if (burst_bad) err_d = 1'b1;
          if (cmd_head.cmd_type == FIFO_CMD_WT) begin
            state_d = ST_WR_DATA;
            wren_d  = 1'b1;
            wdata_d = cmd_head.data;
            mask_d  = cmd_head.mask;
            addr_d  = line_addr(cmd_head.addr);
            burst_d = '0;
            cmd_d   = APP_CMD_WR;
          end else if (rsp_fits) begin
            state_d  = ST_RD_CMD;
            cmd_en_d = 1'b1;
            cmd_d    = APP_CMD_RD;
            addr_d   = line_addr(cmd_head.addr);
            burst_d  = eff_burst;
          end
        end
      end
      ST_WR_DATA: begin
        if (app_wdata_rdy) begin
          wren_d   = 1'b0;
          cmd_en_d = 1'b1;
          state_d  = ST_WR_CMD;
        end
      end
      ST_WR_CMD: begin
        if (app_cmd_rdy) begin
          cmd_en_d = 1'b0;
          cmd_pop  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_CMD: begin
        if (app_cmd_rdy) begin
          cmd_en_d = 1'b0;
          cmd_pop  = 1'b1;
          beats_d  = {1'b0, burst_q} + 1'b1;
          state_d  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (app_rd_data_valid) begin
          rsp_push = 1'b1;
          beats_d  = beats_q - 1'b1;
          if (beats_q == 1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cmd_en_q <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      burst_q  <= '0;
      wren_q   <= 1'b0;
      wdata_q  <= '0;
      mask_q   <= '0;
      beats_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_en_q <= cmd_en_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      wren_q   <= wren_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      beats_q  <= beats_d;
      err_q    <= err_d;
    end
  end

  assign app_cmd_en       = cmd_en_q;
  assign app_cmd          = cmd_q;
  assign app_addr         = addr_q;
  assign app_burst_number = burst_q;
  assign app_wren         = wren_q;
  assign app_wdata_end    = wren_q;
  assign app_wdata        = wdata_q;
  assign app_data_mask    = mask_q;
  assign err_burst        = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ddr_cmd_bridge.sv
// tb_ddr_cmd_bridge: directed bench for ddr_cmd_bridge with a scoreboard.
// Stimulus pushes expected DDR commands, write beats and response beats into
// queues; independent monitors pop and compare at each handshake. A small DDR
// read responder returns a known data pattern for every accepted read.
module tb_ddr_cmd_bridge;
  import ddr_bridge_pkg::*;

  logic         clk, rst;
  logic         io_fifo_cmd_valid, io_fifo_cmd_ready, io_fifo_cmd_type;
  logic [26:0]  io_fifo_cmd_addr;
  logic [5:0]   io_fifo_cmd_burst_cnt;
  logic [127:0] io_fifo_cmd_wt_data;
  logic [15:0]  io_fifo_cmd_wt_mask;
  logic         io_fifo_rsp_valid, io_fifo_rsp_ready;
  logic [127:0] io_fifo_rsp_data;
  logic         init_calib_complete;
  logic         app_cmd_en;
  logic [2:0]   app_cmd;
  logic [26:0]  app_addr;
  logic [5:0]   app_burst_number;
  logic         app_cmd_rdy, app_wren, app_wdata_end, app_wdata_rdy;
  logic [127:0] app_wdata;
  logic [15:0]  app_data_mask;
  logic         app_rd_data_valid;
  logic [127:0] app_rd_data;
  logic         err_burst;
  logic [2:0]   dbg_state;

  ddr_cmd_bridge #(.CMD_DEPTH(4), .RSP_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .io_fifo_cmd_valid(io_fifo_cmd_valid), .io_fifo_cmd_ready(io_fifo_cmd_ready),
    .io_fifo_cmd_type(io_fifo_cmd_type), .io_fifo_cmd_addr(io_fifo_cmd_addr),
    .io_fifo_cmd_burst_cnt(io_fifo_cmd_burst_cnt), .io_fifo_cmd_wt_data(io_fifo_cmd_wt_data),
    .io_fifo_cmd_wt_mask(io_fifo_cmd_wt_mask),
    .io_fifo_rsp_valid(io_fifo_rsp_valid), .io_fifo_rsp_ready(io_fifo_rsp_ready),
    .io_fifo_rsp_data(io_fifo_rsp_data),
    .init_calib_complete(init_calib_complete),
    .app_cmd_en(app_cmd_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_burst_number(app_burst_number), .app_cmd_rdy(app_cmd_rdy),
    .app_wren(app_wren), .app_wdata(app_wdata), .app_data_mask(app_data_mask),
    .app_wdata_end(app_wdata_end), .app_wdata_rdy(app_wdata_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .err_burst(err_burst), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [35:0]  exp_cmd_q[$];   // {app_cmd, app_addr, app_burst_number}
  logic [143:0] exp_wr_q[$];    // {app_wdata, app_data_mask}
  logic [127:0] exp_rsp_q[$];
  logic [32:0]  rd_pend_q[$];   // {addr, burst} of reads the DDR model owes
  int n_err = 0;
  int n_chk = 0;
  int last_wr_cyc = -10;
  bit flush_rd = 1'b0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [26:0] a, input int i);
    return {32'hD0D0_0000 | 32'(i), 5'b0, a, 64'hCAFE_F00D_0000_0000 | 64'(i)};
  endfunction

  logic [35:0]  mon_cmd_e;
  logic [143:0] mon_wr_e;
  logic [127:0] mon_rsp_e;

  always @(negedge clk) begin
    if (!rst && app_cmd_en && app_cmd_rdy) begin
      if (exp_cmd_q.size() == 0) begin
        check("cmd_unexpected", {app_cmd, app_addr, app_burst_number}, 36'h0);
      end else begin
        mon_cmd_e = exp_cmd_q.pop_front();
        check("cmd", {app_cmd, app_addr, app_burst_number}, mon_cmd_e);
      end
      if (app_cmd == APP_CMD_WR) check("wr_cmd_follows_data", cyc, last_wr_cyc + 1);
      if (app_cmd == APP_CMD_RD) rd_pend_q.push_back({app_addr, app_burst_number});
    end
  end

  always @(negedge clk) begin
    if (!rst && app_wren && app_wdata_rdy) begin
      check("wdata_end", app_wdata_end, 1'b1);
      if (exp_wr_q.size() == 0) begin
        check("wr_unexpected", {app_wdata, app_data_mask}, 144'h0);
      end else begin
        mon_wr_e = exp_wr_q.pop_front();
        check("wdata", {app_wdata, app_data_mask}, mon_wr_e);
      end
      last_wr_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && io_fifo_rsp_valid && io_fifo_rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        check("rsp_unexpected", io_fifo_rsp_data, 128'h0);
      end else begin
        mon_rsp_e = exp_rsp_q.pop_front();
        check("rsp", io_fifo_rsp_data, mon_rsp_e);
      end
    end
  end

  // ---------------- DDR read responder ----------------
  initial begin
    logic [32:0] p;
    logic [26:0] rd_addr;
    int rd_left, rd_idx;
    rd_left = 0;
    rd_idx = 0;
    rd_addr = '0;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (flush_rd) begin
        rd_left = 0;
        rd_pend_q.delete();
      end
      if (rd_left == 0 && rd_pend_q.size() > 0) begin
        p = rd_pend_q.pop_front();
        rd_addr = p[32:6];
        rd_left = int'(p[5:0]) + 1;
        rd_idx = 0;
      end
      if (rd_left > 0) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = beat_data(rd_addr, rd_idx);
        rd_idx++;
        rd_left--;
      end else begin
        app_rd_data_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive_cmd(input logic t, input logic [26:0] a, input logic [5:0] b,
                           input logic [127:0] d, input logic [15:0] m);
    io_fifo_cmd_type = t;
    io_fifo_cmd_addr = a;
    io_fifo_cmd_burst_cnt = b;
    io_fifo_cmd_wt_data = d;
    io_fifo_cmd_wt_mask = m;
    io_fifo_cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (io_fifo_cmd_ready) begin
        @(posedge clk);
        #1;
        io_fifo_cmd_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    io_fifo_cmd_valid = 1'b0;
    check("cmd_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic expect_wr(input logic [26:0] a_exp, input logic [127:0] d, input logic [15:0] m);
    exp_cmd_q.push_back({APP_CMD_WR, a_exp, 6'd0});
    exp_wr_q.push_back({d, m});
  endtask

  task automatic expect_rd(input logic [26:0] a_exp, input logic [5:0] b_exp);
    exp_cmd_q.push_back({APP_CMD_RD, a_exp, b_exp});
    for (int i = 0; i <= int'(b_exp); i++) exp_rsp_q.push_back(beat_data(a_exp, i));
  endtask

  task automatic wait_idle(input bit inc_rsp, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_cmd_q.size() == 0 && exp_wr_q.size() == 0 && dbg_state == 3'd0 &&
          (!inc_rsp || exp_rsp_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check(name, ok, 1'b1);
  endtask

  logic [26:0]  t3_addr [4] = '{27'h1005, 27'h101F, 27'h1020, 27'h103C};
  logic [26:0]  t3_exp  [4] = '{27'h1000, 27'h1010, 27'h1020, 27'h1030};
  logic [127:0] t3_data [4] = '{128'h1111, 128'h2222_0000_0000_0000_0000, 128'h3333 << 64, {4{32'h4444_4444}}};
  logic [15:0]  t3_mask [4] = '{16'h0000, 16'h000F, 16'hF000, 16'hAAAA};

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    rst = 1'b1;
    init_calib_complete = 1'b0;
    io_fifo_cmd_valid = 1'b0;
    io_fifo_cmd_type = 1'b0;
    io_fifo_cmd_addr = '0;
    io_fifo_cmd_burst_cnt = '0;
    io_fifo_cmd_wt_data = '0;
    io_fifo_cmd_wt_mask = '0;
    io_fifo_rsp_ready = 1'b1;
    app_cmd_rdy = 1'b1;
    app_wdata_rdy = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_cmd_en", app_cmd_en, 1'b0);
    check("rst_wren", {app_wren, app_wdata_end}, 2'b00);
    check("rst_rsp_valid", io_fifo_rsp_valid, 1'b0);
    check("rst_err", err_burst, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_ready_nocalib", io_fifo_cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_calib", io_fifo_cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    init_calib_complete = 1'b1;
    @(negedge clk);
    check("ready_after_calib", io_fifo_cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single write: low address bits dropped, mask passed through
    expect_wr(27'h0000120, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32AA, 16'hFF00);
    drive_cmd(FIFO_CMD_WT, 27'h0000123, 6'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32AA, 16'hFF00);
    wait_idle(1'b1, "t1_idle");
    @(negedge clk);
    check("t1_cmd_ready", io_fifo_cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // Read burst of 4 beats
    expect_rd(27'h40, 6'd3);
    drive_cmd(FIFO_CMD_RD, 27'h40, 6'd3, '0, '0);
    wait_idle(1'b1, "t2_idle");

    // Four writes while write data is back-pressured: command FIFO fills
    app_wdata_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_wr(t3_exp[k], t3_data[k], t3_mask[k]);
      drive_cmd(FIFO_CMD_WT, t3_addr[k], 6'd0, t3_data[k], t3_mask[k]);
    end
    io_fifo_cmd_valid = 1'b1;
    io_fifo_cmd_addr = 27'h7FF0;
    @(negedge clk);
    check("t3_full_ready", io_fifo_cmd_ready, 1'b0);
    check("t3_no_wdata_yet", exp_wr_q.size(), 4);
    @(posedge clk);
    #1;
    io_fifo_cmd_valid = 1'b0;
    app_wdata_rdy = 1'b1;
    wait_idle(1'b1, "t3_idle");

    // Read of 8 beats held back until two unconsumed beats drain
    io_fifo_rsp_ready = 1'b0;
    expect_rd(27'h80, 6'd1);
    drive_cmd(FIFO_CMD_RD, 27'h80, 6'd1, '0, '0);
    wait_idle(1'b0, "t4_fill");
    expect_rd(27'h100, 6'd7);
    drive_cmd(FIFO_CMD_RD, 27'h100, 6'd7, '0, '0);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_held_cmd", exp_cmd_q.size(), 1);
    check("t4_no_cmd_en", app_cmd_en, 1'b0);
    check("t4_rsp_valid", io_fifo_rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    io_fifo_rsp_ready = 1'b1;
    wait_idle(1'b1, "t4_idle");
    check("t4_err_clear", err_burst, 1'b0);

    // Illegal bursts: flagged, sticky, executed as single beat
    expect_wr(27'h2000, 128'hBEEF, 16'h0001);
    drive_cmd(FIFO_CMD_WT, 27'h2000, 6'd2, 128'hBEEF, 16'h0001);
    wait_idle(1'b1, "t5_idle_a");
    check("t5_err_set", err_burst, 1'b1);
    expect_wr(27'h2010, 128'hF00D, 16'h0000);
    drive_cmd(FIFO_CMD_WT, 27'h2018, 6'd0, 128'hF00D, 16'h0000);
    wait_idle(1'b1, "t5_idle_b");
    check("t5_err_sticky", err_burst, 1'b1);
    expect_rd(27'h2100, 6'd0);
    drive_cmd(FIFO_CMD_RD, 27'h2100, 6'd8, '0, '0);
    wait_idle(1'b1, "t5_idle_c");

    // Reset in the middle of a 4-beat read, after beat 2
    io_fifo_rsp_ready = 1'b0;
    expect_rd(27'h300, 6'd3);
    drive_cmd(FIFO_CMD_RD, 27'h30A, 6'd3, '0, '0);
    seen = 0;
    for (int i = 0; i < 50 && seen < 2; i++) begin
      @(negedge clk);
      if (dbg_state == 3'd4 && app_rd_data_valid) seen++;
    end
    @(posedge clk);
    #1;
    check("t6_two_beats_seen", seen, 2);
    rst = 1'b1;
    init_calib_complete = 1'b0;
    flush_rd = 1'b1;
    @(negedge clk);
    check("t6_rst_strobes", {app_cmd_en, app_wren, app_wdata_end, io_fifo_rsp_valid}, 4'b0);
    check("t6_rst_addr", {app_cmd, app_addr, app_burst_number}, 36'h0);
    check("t6_rst_data", {app_wdata, app_data_mask}, 144'h0);
    check("t6_rst_rsp_data", io_fifo_rsp_data, 128'h0);
    check("t6_rst_err", err_burst, 1'b0);
    check("t6_rst_state", dbg_state, 3'd0);
    check("t6_rst_ready", io_fifo_cmd_ready, 1'b0);
    exp_rsp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    flush_rd = 1'b0;
    io_fifo_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    init_calib_complete = 1'b1;
    @(negedge clk);
    check("t6_ready_after", io_fifo_cmd_ready, 1'b1);
    check("t6_rsp_empty", io_fifo_rsp_valid, 1'b0);
    @(posedge clk);
    #1;

    // Bridge is usable after the reset
    expect_rd(27'h400, 6'd0);
    drive_cmd(FIFO_CMD_RD, 27'h400, 6'd0, '0, '0);
    wait_idle(1'b1, "t7_idle");

    check("end_cmd_q_empty", exp_cmd_q.size(), 0);
    check("end_wr_q_empty", exp_wr_q.size(), 0);
    check("end_rsp_q_empty", exp_rsp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
